// File: rtl/sc_diff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_diff_pkg : shared types and constants for the stream differentiator     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package sc_diff_pkg;

  localparam int DATA_WIDTH_DEF = 512;
  localparam int SKID_DEPTH     = 2;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] d;
    logic                      wrap;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/sc_diff_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_diff_if : accumulated-stream input, increment-stream output and clear   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface sc_diff_if
  import sc_diff_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
);
  logic                  clear_i;
  logic                  data_valid_i;
  logic                  data_ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_valid_o;
  logic                  data_ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  wrap_o;
  logic [CNT_WIDTH-1:0]  cnt_o;

  modport master (
    output clear_i, data_valid_i, data_i, data_ready_i,
    input  data_ready_o, data_valid_o, data_o, wrap_o, cnt_o
  );

  modport slave (
    input  clear_i, data_valid_i, data_i, data_ready_i,
    output data_ready_o, data_valid_o, data_o, wrap_o, cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sc_diff_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_diff_skid : 2-entry FIFO-ordered skid buffer, registered in-ready       |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module sc_diff_skid
  import sc_diff_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [1:0]       w_count_nxt;
  logic             w_push;
  logic             w_pop;

  assign out_valid_o = (r_count != 2'd0);
  assign out_data_o  = r_mem[0];
  assign in_ready_o  = r_in_ready;
  assign w_push      = in_valid_i & r_in_ready;
  assign w_pop       = out_valid_o & out_ready_i;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else if (flush_i) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'(SKID_DEPTH));
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
      end
      // A push lands in the first free slot as seen after this cycle's pop.
      if (w_push) begin
        if (w_pop ? (r_count == 2'd1) : (r_count == 2'd0)) begin
          r_mem[0] <= in_data_i;
        end else begin
          r_mem[1] <= in_data_i;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_diff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_diff : stream differentiator, out = in - previous_in mod 2^DATA_WIDTH   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sc_diff
  import sc_diff_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16,
  parameter bit FIRST_PASS = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  sc_diff_if.slave    bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic                  wrap;
  } beat_t;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [CNT_WIDTH-1:0]  r_cnt;
  beat_t                 w_push_beat;
  beat_t                 w_out_beat;
  logic                  w_push;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_in_hs;
  logic                  w_out_hs;

  assign w_in_hs  = bus.data_valid_i & w_in_ready;
  assign w_out_hs = w_out_valid & bus.data_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= PRIME;
    end else if (bus.clear_i) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // prev is zero whenever the FSM sits in PRIME, so the same subtractor
  // yields data_i - 0 for the first pass.
  always_comb begin
    w_state_nxt      = r_state;
    w_push           = 1'b0;
    w_push_beat.d    = bus.data_i - r_prev;
    w_push_beat.wrap = 1'b0;
    case (r_state)
      PRIME: begin
        if (w_in_hs) begin
          w_push      = FIRST_PASS;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_push           = w_in_hs;
        w_push_beat.wrap = (bus.data_i < r_prev);
      end
      default: w_state_nxt = PRIME;
    endcase
    if (bus.clear_i) begin
      w_push = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else if (bus.clear_i) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_in_hs) begin
        r_prev <= bus.data_i;
      end
      if (w_out_hs && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  sc_diff_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (bus.clear_i),
    .in_valid_i  (w_push),
    .in_ready_o  (w_in_ready),
    .in_data_i   (w_push_beat),
    .out_valid_o (w_out_valid),
    .out_ready_i (bus.data_ready_i),
    .out_data_o  (w_out_beat)
  );

  assign bus.data_ready_o = w_in_ready;
  assign bus.data_valid_o = w_out_valid;
  assign bus.data_o       = w_out_beat.d;
  assign bus.wrap_o       = w_out_beat.wrap;
  assign bus.cnt_o        = r_cnt;

endmodule
`default_nettype wire
